// File: rtl/gb_stream_ctrl.sv
// rtl/gb_stream_ctrl.sv - Gaussian-blur frame sequencer: input stream, line-buffer/stencil control, 2-entry output skid buffer (optional GB_PERF_CNT_EN perf counters)
module gb_stream_ctrl #(
    parameter int IMG_W = 488,
    parameter int IMG_H = 648,
    parameter int WIN   = 9,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] arg_1_TDATA,
    input  logic          arg_1_TVALID,
    output logic          arg_1_TREADY,
    output logic [DW-1:0] arg_0_TDATA,
    output logic          arg_0_TVALID,
    input  logic          arg_0_TREADY,
    output logic          lb_we,
    output logic [2:0]    lb_row,
    output logic [8:0]    lb_col,
    output logic [DW-1:0] lb_wdata,
    output logic          st_shift,
    input  logic [DW-1:0] res_data,
    output logic          busy,
    output logic          frame_done
`ifdef GB_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   frame_cnt
`endif
);

    // Row counter is at least 3 bits so the line-buffer row select is always available.
    localparam int RW = (IMG_H > 8) ? $clog2(IMG_H) : 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [8:0]    col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          accept;
    logic          pop;
    logic          emit;
    logic          emit_d;
    logic [1:0]    occ;
    logic [2:0]    inflight;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;

    // Handshakes; input ready only when the skid buffer can absorb everything already in flight.
    assign pop          = arg_0_TVALID & arg_0_TREADY;
    assign inflight     = {1'b0, occ} + {2'b00, emit_d} - {2'b00, pop};
    assign arg_1_TREADY = (state == S_STREAM) && (inflight < 3'd2);
    assign accept       = arg_1_TVALID & arg_1_TREADY;

    assign col_last = (col == 9'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign emit     = accept && (row >= RW'(WIN - 1)) && (col >= 9'(WIN - 1));

    assign lb_we    = accept;
    assign st_shift = accept;
    assign lb_row   = row[2:0];
    assign lb_col   = col;
    assign lb_wdata = arg_1_TDATA;

    assign arg_0_TVALID = (occ != 2'd0);
    assign arg_0_TDATA  = head;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                busy = 1'b1;
                if (accept && col_last && row_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((occ == 2'd0) && !emit_d) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster position of the next pixel to accept; cleared when a frame starts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if ((state == S_IDLE) && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Result capture one cycle after the stencil shift, into an in-order 2-entry skid buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            emit_d <= 1'b0;
            occ    <= 2'd0;
            head   <= '0;
            tail   <= '0;
        end else begin
            emit_d <= emit;
            case (occ)
                2'd0: begin
                    if (emit_d) begin
                        head <= res_data;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (emit_d && pop) begin
                        head <= res_data;
                    end else if (emit_d) begin
                        tail <= res_data;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (emit_d) begin
                            tail <= res_data;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef GB_PERF_CNT_EN
    // Saturating stall and frame counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if ((state == S_STREAM) && arg_1_TVALID && !arg_1_TREADY && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (frame_done && (frame_cnt != 32'hFFFF_FFFF)) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gb_stream_ctrl.sv
// tb/tb_gb_stream_ctrl.sv - randomized self-checking bench for gb_stream_ctrl with a frame-level reference model
module tb_gb_stream_ctrl;

    localparam int TW   = 16;
    localparam int TH   = 12;
    localparam int TWIN = 9;
    localparam int NPIX = TW * TH;
    localparam int NOUT = (TH - TWIN + 1) * (TW - TWIN + 1);

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] arg_1_TDATA;
    logic       arg_1_TVALID;
    logic       arg_1_TREADY;
    logic [7:0] arg_0_TDATA;
    logic       arg_0_TVALID;
    logic       arg_0_TREADY;
    logic       lb_we;
    logic [2:0] lb_row;
    logic [8:0] lb_col;
    logic [7:0] lb_wdata;
    logic       st_shift;
    logic [7:0] res_data;
    logic       busy;
    logic       frame_done;
`ifdef GB_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] frame_cnt;
`endif

    gb_stream_ctrl #(.IMG_W(TW), .IMG_H(TH), .WIN(TWIN), .DW(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .arg_1_TDATA(arg_1_TDATA), .arg_1_TVALID(arg_1_TVALID), .arg_1_TREADY(arg_1_TREADY),
        .arg_0_TDATA(arg_0_TDATA), .arg_0_TVALID(arg_0_TVALID), .arg_0_TREADY(arg_0_TREADY),
        .lb_we(lb_we), .lb_row(lb_row), .lb_col(lb_col), .lb_wdata(lb_wdata),
        .st_shift(st_shift), .res_data(res_data), .busy(busy), .frame_done(frame_done)
`ifdef GB_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state (frame level).
    bit         frame_on;
    bit         stream_m;
    bit         lit_frame;
    int         acc_n;
    int         out_n;
    int         we_n;
    int         start_cyc;
    int         last_pop_cyc;
    int         frames_done;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp_q[$];
    int         arr_q[$];

    function automatic logic [7:0] pix(input int n);
        int r;
        int c;
        r = n / TW;
        c = n % TW;
        return 8'((r * 16 + c) & 8'hFF);
    endfunction

    function automatic logic [7:0] blur(input logic [7:0] p);
        return p ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle the DUT outputs are checked against the frame model.
    always @(negedge clk) begin
        bit   pop_now;
        bit   acc_now;
        bit   valid_exp;
        bit   ready_exp;
        bit   fd_exp;
        bit   idle_m;
        int   arrived;
        int   r;
        int   c;
        cyc++;
        if (!rst) begin
            frame_on   = 0;
            stream_m   = 0;
            lit_frame  = 0;
            acc_n      = 0;
            out_n      = 0;
            we_n       = 0;
            prev_stall = 0;
            exp_q.delete();
            arr_q.delete();
        end else begin
            idle_m    = !frame_on;
            pop_now   = arg_0_TVALID && arg_0_TREADY;
            acc_now   = arg_1_TVALID && arg_1_TREADY;
            valid_exp = (exp_q.size() > 0) && (arr_q[0] <= cyc);
            ready_exp = stream_m && ((exp_q.size() - int'(pop_now)) < 2);
            fd_exp    = frame_on && (acc_n == NPIX) && (exp_q.size() == 0) && (cyc == last_pop_cyc + 2);
            arrived = 0;
            foreach (arr_q[i]) if (arr_q[i] <= cyc) arrived++;

            check("arg_1_TREADY", arg_1_TREADY, ready_exp);
            check("arg_0_TVALID", arg_0_TVALID, valid_exp);
            if (valid_exp) check("arg_0_TDATA", arg_0_TDATA, exp_q[0]);
            if (prev_stall) begin
                check("hold_valid", arg_0_TVALID, 1);
                check("hold_data", arg_0_TDATA, prev_data);
            end
            check("skid_occ_le2", arrived <= 2, 1);
            check("lb_we", lb_we, acc_now);
            check("st_shift", st_shift, acc_now);
            check("busy", busy, frame_on && !fd_exp);
            check("frame_done", frame_done, fd_exp);
            if (acc_now) begin
                r = acc_n / TW;
                c = acc_n % TW;
                check("lb_row", lb_row, r % 8);
                check("lb_col", lb_col, c);
                check("lb_wdata", lb_wdata, pix(acc_n));
            end

            if (pop_now && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(arr_q.pop_front());
                out_n++;
                last_pop_cyc = cyc;
                if (lit_frame && out_n == 1) begin
                    check("first_out_cycle", cyc - start_cyc, 139);
                    check("first_out_data", arg_0_TDATA, 8'h2D);
                end
            end
            if (acc_now) begin
                r = acc_n / TW;
                c = acc_n % TW;
                if (r >= TWIN - 1 && c >= TWIN - 1) begin
                    exp_q.push_back(blur(pix(acc_n)));
                    arr_q.push_back(cyc + 2);
                end
                acc_n++;
                we_n++;
                if (acc_n == NPIX) stream_m = 0;
            end
            if (fd_exp) begin
                check("outputs_per_frame", out_n, 32);
                check("lb_we_per_frame", we_n, 192);
                if (lit_frame) check("frame_done_cycle", cyc - start_cyc, 196);
                frame_on  = 0;
                lit_frame = 0;
                frames_done++;
            end
            if (start && idle_m) begin
                frame_on  = 1;
                stream_m  = 1;
                lit_frame = (frames_done == 0);
                acc_n     = 0;
                out_n     = 0;
                we_n      = 0;
                start_cyc = cyc;
                exp_q.delete();
                arr_q.delete();
            end
            prev_stall = arg_0_TVALID && !arg_0_TREADY;
            prev_data  = arg_0_TDATA;
        end
    end

    // Datapath stand-in: result for the accepted pixel appears the cycle after st_shift.
    bit         dp_pend;
    logic [7:0] dp_pix;

    task automatic drive_dp();
        res_data = dp_pend ? blur(dp_pix) : 8'($urandom);
    endtask

    task automatic idle(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            drive_dp();
            start        = 0;
            arg_1_TVALID = 1'($urandom);
            arg_1_TDATA  = 8'($urandom);
            arg_0_TREADY = 1'($urandom);
            @(negedge clk);
            dp_pend = 0;
        end
    endtask

    // mode 0: full rate; 1: output ready 1,0,0,1; 2: random. rst_at >= 0 aborts the frame with a reset.
    task automatic run_frame(input int mode, input int rst_at);
        int n;
        int cycles;
        bit done;
        n = 0;
        cycles = 0;
        done = 0;
        do begin
            @(posedge clk);
            #1;
            drive_dp();
            if (rst_at >= 0 && n >= rst_at) begin
                rst   = 0;
                start = 0;
                @(negedge clk);
                dp_pend = 0;
                @(posedge clk);
                #1;
                rst          = 1;
                arg_1_TVALID = 0;
                return;
            end
            start        = (cycles == 0);
            arg_1_TVALID = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
            arg_1_TDATA  = arg_1_TVALID ? pix(n) : 8'($urandom);
            arg_0_TREADY = (mode == 0) ? 1'b1 :
                           (mode == 1) ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'($urandom);
            @(negedge clk);
            dp_pend = arg_1_TVALID && arg_1_TREADY;
            dp_pix  = arg_1_TDATA;
            if (dp_pend) n++;
            if (frame_done) done = 1;
            cycles++;
        end while (!done && cycles < 4000);
        if (!done) check("frame_timeout", 0, 1);
    endtask

    initial begin
        rst          = 0;
        start        = 0;
        arg_1_TVALID = 0;
        arg_1_TDATA  = 0;
        arg_0_TREADY = 0;
        res_data     = 0;
        dp_pend      = 0;
        dp_pix       = 0;
        frames_done  = 0;
        last_pop_cyc = -10;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("rst_arg_0_TVALID", arg_0_TVALID, 0);
        check("rst_arg_0_TDATA", arg_0_TDATA, 0);
        check("rst_arg_1_TREADY", arg_1_TREADY, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_lb_we", lb_we, 0);
        check("rst_st_shift", st_shift, 0);
        check("rst_lb_row", lb_row, 0);
        check("rst_lb_col", lb_col, 0);
        check("rst_lb_wdata", lb_wdata, 0);

        run_frame(0, -1);
        idle(5);
        run_frame(1, -1);
        idle(5);
        run_frame(2, 9 * TW + 5);
        @(negedge clk);
        check("midrst_arg_0_TVALID", arg_0_TVALID, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_arg_1_TREADY", arg_1_TREADY, 0);
        idle(20);
        run_frame(2, -1);
        idle(5);
        check("frames_completed", frames_done, 3);
`ifdef GB_PERF_CNT_EN
        check("frame_cnt", frame_cnt, frames_done);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gb_stream_ctrl.md
Name: gb_stream_ctrl

Overview:
- Frame-level sequencer for the Gaussian-blur stencil datapath.
- Accepts the input pixel stream (arg_1 side) and steps the row/column counters.
- Drives the write/shift controls of the 8-row line buffer and the 9x9 stencil window.
- Captures the blur result from the datapath and issues it on the output stream (arg_0 side) through a 2-entry skid buffer with full backpressure.

Parameters:
- IMG_W, 488, pixels per row; col counter range 0..IMG_W-1.
- IMG_H, 648, rows per frame; row counter range 0..IMG_H-1.
- WIN, 9, stencil edge; line-buffer rows = WIN-1 = 8 (power of two).
- DW, 8, pixel width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise.
- arg_1_TDATA  in  DW  input pixel.
- arg_1_TVALID  in  1  input valid.
- arg_1_TREADY  out  1  input ready.
- arg_0_TDATA  out  DW  output pixel.
- arg_0_TVALID  out  1  output valid.
- arg_0_TREADY  in  1  output ready.
- lb_we  out  1  line-buffer write strobe.
- lb_row  out  3  line-buffer row select, equal to row mod 8.
- lb_col  out  9  line-buffer write/read column.
- lb_wdata  out  DW  line-buffer write data.
- st_shift  out  1  shift the stencil left by one column and load the new column.
- res_data  in  DW  datapath blur result for the current stencil; valid the cycle after st_shift.
- busy  out  1  high in STREAM or DRAIN.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values: state=IDLE, col=0, row=0, occ=0, emit_d=0, arg_0_TVALID=0, arg_0_TDATA=0, arg_1_TREADY=0, busy=0, frame_done=0. lb_we, st_shift, lb_row, lb_col and lb_wdata derive from the cleared state and counters.
- Reset mid-frame discards all in-flight data; no frame_done is issued.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE: start -> STREAM; col and row are cleared.
  - STREAM: accepting the last pixel (col==IMG_W-1 and row==IMG_H-1) -> DRAIN.
  - DRAIN: occ==0 and emit_d==0 -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- accept = arg_1_TVALID & arg_1_TREADY.
- pop = arg_0_TVALID & arg_0_TREADY.
- arg_1_TREADY = (state==STREAM) & (occ + emit_d - pop < 2). This is combinational from arg_0_TREADY and sustains 1 pixel/clk when arg_0_TREADY is held high.
- lb_we = st_shift = accept, combinational.
- lb_row = row[2:0]; lb_col = col; lb_wdata = arg_1_TDATA.
- Counters:
  - col increments on accept and wraps IMG_W-1 -> 0.
  - row increments on a col wrap and wraps IMG_H-1 -> 0.
  - There is no over-count past the last pixel, because the FSM leaves STREAM.
- emit = accept & (row >= WIN-1) & (col >= WIN-1). This gives (IMG_H-8)*(IMG_W-8) outputs per frame (307200 at defaults).
- emit_d is emit registered. When emit_d==1, res_data is pushed into the skid buffer (latency: accept -> result visible on arg_0 after 2 clk when the buffer is empty).
- Skid buffer:
  - 2 entries, in-order; arg_0_TDATA/TVALID are driven from the head register.
  - Push and pop in the same cycle leave occ unchanged.
  - Push when occ==2 cannot occur because of the ready rule; the testbench asserts this.
- Output hold: arg_0_TVALID must not drop and arg_0_TDATA must not change while arg_0_TREADY==0.
- start while busy is ignored. start in the same cycle as DONE is ignored.

Optional Feature:
- Macro: GB_PERF_CNT_EN.
- Defined: adds two 32-bit outputs.
  - stall_cnt: counts cycles in STREAM with arg_1_TVALID=1 and arg_1_TREADY=0.
  - frame_cnt: counts frame_done pulses.
  - Both clear on rst and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with rst=0 for 3 clk, then rst=1 -> all outputs at their reset values, arg_1_TREADY=0 until start.
- IMG_W=16, IMG_H=12, start, stream pixel value = (row*16+col)&8'hFF with arg_0_TREADY=1 -> exactly 32 outputs, first at the accept of row 8 col 8 plus 2 clk, 1 output/clk within a row, then frame_done.
- Same frame with arg_0_TREADY toggling 1,0,0,1 -> no output lost or duplicated, TDATA stable while stalled, arg_1_TREADY low whenever occ + emit_d - pop >= 2.
- lb checks with IMG_W=16: lb_row wraps 7->0 at row 8; lb_col wraps 15->0; lb_we=1 exactly 192 times per frame.
- Drive rst=0 mid-row 9 -> next clk state=IDLE, occ=0, arg_0_TVALID=0, no frame_done; a new start runs a clean frame.
- With GB_PERF_CNT_EN: hold arg_0_TREADY=0 for 10 clk during the valid region -> stall_cnt grows by 10 minus buffer slack; frame_cnt=2 after two frames.
